psram_rd_dly_cal: RTL and testbench
===================================

Name: psram_rd_dly_cal

Overview:
- Synthesizable read-capture calibration controller for the PSRAM PHY DQ/RWDS datapath.
- Sweeps the RWDS-to-DQ capture delay tap, issues a calibration read burst per tap, and compares each word against a fixed pattern.
- Finds the longest contiguous passing tap window and programs its centre into the PHY delay line.
- Sits between the PSRAM controller's read port and the PHY delay-tap configuration input.

Parameters:
- TAP_W, 5: delay tap width; 2**TAP_W taps, swept 0..2**TAP_W-1.
- BURST_LEN, 8: data words expected per calibration read.
- PATTERN, 16'hA55A: expected word; word k compares against PATTERN rotated left by k.
- MIN_WIN, 4: minimum passing window length in taps for success.
- SETTLE_CYC, 16: idle cycles after each tap change before the read request.
- TIMEOUT, 1024: maximum cycles from acknowledge to the last data word.
- DEF_TAP, 8: tap value after reset and after a failed calibration.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_cal_start  in  1  single-cycle start pulse; ignored while o_cal_busy is high.
- o_cal_busy  out  1  calibration in progress.
- o_cal_done  out  1  single-cycle pulse at completion, success or fail.
- o_cal_fail  out  1  sticky; valid from o_cal_done until the next start.
- o_err_code  out  2  0 ok, 1 window too small, 2 read timeout.
- o_dly_tap  out  TAP_W  delay tap driven to the PHY.
- o_rd_req  out  1  calibration read request; held until acknowledged.
- i_rd_ack  in  1  controller accepted the request.
- i_rd_vld  in  1  read data word valid.
- i_rd_data  in  16  captured DQ word.
- o_win_start  out  TAP_W  first tap of the best window.
- o_win_len  out  TAP_W+1  length of the best window.

Behaviour:
- Reset values: FSM IDLE; o_dly_tap=DEF_TAP; o_win_start=0; o_win_len=0; o_err_code=0; all 1-bit outputs 0. Reset mid-operation aborts immediately with no o_cal_done.
- FSM states: IDLE, SET_TAP, SETTLE, REQ, CAPTURE, EVAL, CENTER, DONE.
- IDLE: on i_cal_start, clear the window trackers, set tap=0, go to SET_TAP. o_cal_busy rises the next cycle.
- SET_TAP: drive o_dly_tap=tap, go to SETTLE.
- SETTLE: wait exactly SETTLE_CYC cycles, go to REQ.
- REQ: assert o_rd_req. Go to CAPTURE on the cycle i_rd_ack=1; o_rd_req drops the next cycle. Clear the word counter and pass flag.
- CAPTURE: on each i_rd_vld, compare i_rd_data with rotl(PATTERN, word_cnt) and clear the pass flag on any mismatch. After BURST_LEN words go to EVAL. Data outside CAPTURE is ignored.
- CAPTURE timeout: if the cycle count reaches TIMEOUT first, set err=2 and fail, go to DONE.
- EVAL, pass: cur_len++; set cur_start=tap when cur_len was 0.
- EVAL, fail: close the current run; cur_len=0.
- EVAL, run close: if cur_len > best_len (strictly greater, so the lowest-tap window wins a tie), best takes the current run.
- EVAL, last tap: at tap 2**TAP_W-1, close any open run, then go to CENTER. Otherwise tap++ and go to SET_TAP. There is no wrap-around.
- CENTER, success: when best_len >= MIN_WIN, o_dly_tap = best_start + (best_len>>1), computed at TAP_W+1 bits (never overflows).
- CENTER, failure: otherwise err=1 and o_dly_tap=DEF_TAP.
- DONE: one-cycle o_cal_done; o_win_* and o_err_code update the same cycle; busy drops; go to IDLE.
- Taps always step by one per pass; latency per tap = 2 + SETTLE_CYC + ack wait + burst.

Optional Feature:
- Macro: PSRAM_CAL_PASSMAP_EN.
- Defined: adds output o_pass_map[2**TAP_W-1:0]. Bit t is set in EVAL if tap t passed. Cleared on start and on reset; held after done.
- Undefined: the port and its register are absent; behaviour is otherwise identical.

Decomposition:
- Package psram_cal_pkg: FSM state enum, err_code enum (CAL_OK, CAL_WIN_SMALL, CAL_TIMEOUT), rotl function.
- Sub-module psram_cal_win_track: longest-run tracker with inputs clr, step, pass, last and outputs best_start, best_len.

Test Plan:
- Taps 10..19 pass, all others corrupt -> o_win_start=10, o_win_len=10, o_dly_tap=15, o_err_code=0, one o_cal_done pulse.
- Passing runs 3..6 and 20..23 (equal length) -> o_win_start=3, o_dly_tap=5. Runs 3..6 and 20..26 -> o_win_start=20, o_dly_tap=23.
- Only taps 0..2 pass -> o_cal_fail=1, o_err_code=1, o_dly_tap=8. Taps 28..31 pass -> window closes at the last tap, o_dly_tap=30.
- i_rd_vld withheld at tap 4 -> done after TIMEOUT cycles, o_err_code=2, o_dly_tap=8. A second i_cal_start while busy has no effect.
- i_rst asserted during CAPTURE -> next cycle o_dly_tap=8, busy=0, no done. A new start recalibrates cleanly. o_rd_req holds through a 5-cycle ack delay.
- With PSRAM_CAL_PASSMAP_EN and taps 10..19 passing -> o_pass_map=32'h000F_FC00.

Source files
------------

// File: rtl/psram_cal_pkg.sv
// Shared types and helpers for the PSRAM read-capture delay calibration.
package psram_cal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_TAP,
        ST_SETTLE,
        ST_REQ,
        ST_CAPTURE,
        ST_EVAL,
        ST_CENTER,
        ST_DONE
    } cal_state_e;

    typedef enum logic [1:0] {
        CAL_OK        = 2'd0,
        CAL_WIN_SMALL = 2'd1,
        CAL_TIMEOUT   = 2'd2
    } cal_err_e;

    // Rotate a 16-bit word left by n positions.
    function automatic logic [15:0] rotl(input logic [15:0] v, input logic [3:0] n);
        return (v << n) | (v >> (5'd16 - {1'b0, n}));
    endfunction

endpackage

// File: rtl/psram_cal_win_track.sv
// Longest contiguous passing-run tracker; the lowest tap wins a tie.
module psram_cal_win_track #(
    parameter int unsigned TAP_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             step,
    input  logic             pass,
    input  logic             last,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] best_start,
    output logic [TAP_W:0]   best_len
);

    localparam int unsigned LEN_W = TAP_W + 1;

    logic [TAP_W-1:0] cur_start;
    logic [LEN_W-1:0] cur_len;
    logic [TAP_W-1:0] run_start;
    logic [LEN_W-1:0] run_len;

    // Run as it would look after including the current passing tap.
    always_comb begin
        run_len   = cur_len + LEN_W'(1);
        run_start = (cur_len == '0) ? tap : cur_start;
    end

    // Extend the open run on pass; close it on fail or at the last tap.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (step) begin
            if (pass) begin
                if (last) begin
                    if (run_len > best_len) begin
                        best_start <= run_start;
                        best_len   <= run_len;
                    end
                    cur_len <= '0;
                end else begin
                    cur_start <= run_start;
                    cur_len   <= run_len;
                end
            end else begin
                if (cur_len > best_len) begin
                    best_start <= cur_start;
                    best_len   <= cur_len;
                end
                cur_len <= '0;
            end
        end
    end

endmodule

// File: rtl/psram_rd_dly_cal.sv
// PSRAM read-capture delay calibration: sweeps every delay tap, issues a
// pattern read per tap, and programs the centre of the longest passing window.
// Optional: define PSRAM_CAL_PASSMAP_EN to expose the per-tap pass map.
module psram_rd_dly_cal
    import psram_cal_pkg::*;
#(
    parameter int unsigned TAP_W      = 5,
    parameter int unsigned BURST_LEN  = 8,
    parameter logic [15:0] PATTERN    = 16'hA55A,
    parameter int unsigned MIN_WIN    = 4,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned DEF_TAP    = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cal_start,
    output logic               o_cal_busy,
    output logic               o_cal_done,
    output logic               o_cal_fail,
    output logic [1:0]         o_err_code,
    output logic [TAP_W-1:0]   o_dly_tap,
    output logic               o_rd_req,
    input  logic               i_rd_ack,
    input  logic               i_rd_vld,
    input  logic [15:0]        i_rd_data,
    output logic [TAP_W-1:0]   o_win_start,
    output logic [TAP_W:0]     o_win_len
`ifdef PSRAM_CAL_PASSMAP_EN
    ,
    output logic [2**TAP_W-1:0] o_pass_map
`endif
);

    localparam int unsigned LEN_W = TAP_W + 1;
    localparam int unsigned NTAP  = 2**TAP_W;
    localparam int unsigned SCW   = $clog2(SETTLE_CYC + 1);
    localparam int unsigned WCW   = $clog2(BURST_LEN + 1);
    localparam int unsigned TCW   = $clog2(TIMEOUT + 1);

    cal_state_e       state_q;
    cal_state_e       state_d;
    cal_err_e         err_d;
    logic [TAP_W-1:0] tap_q;
    logic [SCW-1:0]   settle_cnt;
    logic [WCW-1:0]   word_cnt;
    logic [TCW-1:0]   to_cnt;
    logic             pass_q;
    logic             word_ok;
    logic             last_tap;
    logic             trk_clr;
    logic             trk_step;
    logic [TAP_W-1:0] fin_tap;
    logic [LEN_W-1:0] center;
    logic [TAP_W-1:0] best_start;
    logic [LEN_W-1:0] best_len;

    // Longest passing window across the sweep.
    psram_cal_win_track #(
        .TAP_W (TAP_W)
    ) u_win_track (
        .clk        (i_clk),
        .rst        (i_rst),
        .clr        (trk_clr),
        .step       (trk_step),
        .pass       (pass_q),
        .last       (last_tap),
        .tap        (tap_q),
        .best_start (best_start),
        .best_len   (best_len)
    );

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, tracker strobes and the completion result.
    always_comb begin
        state_d  = state_q;
        err_d    = CAL_OK;
        trk_clr  = 1'b0;
        trk_step = 1'b0;
        fin_tap  = TAP_W'(DEF_TAP);
        last_tap = (tap_q == TAP_W'(NTAP - 1));
        word_ok  = (i_rd_data == rotl(PATTERN, 4'(word_cnt)));
        center   = LEN_W'(best_start) + (best_len >> 1);
        case (state_q)
            ST_IDLE: begin
                if (i_cal_start) begin
                    trk_clr = 1'b1;
                    state_d = ST_SET_TAP;
                end
            end
            ST_SET_TAP: state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_cnt == SCW'(SETTLE_CYC - 1)) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_rd_ack) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (i_rd_vld && (word_cnt == WCW'(BURST_LEN - 1))) begin
                    state_d = ST_EVAL;
                end else if (to_cnt == TCW'(TIMEOUT - 1)) begin
                    err_d   = CAL_TIMEOUT;
                    state_d = ST_DONE;
                end
            end
            ST_EVAL: begin
                trk_step = 1'b1;
                state_d  = last_tap ? ST_CENTER : ST_SET_TAP;
            end
            ST_CENTER: begin
                if (best_len >= LEN_W'(MIN_WIN)) begin
                    fin_tap = center[TAP_W-1:0];
                end else begin
                    err_d = CAL_WIN_SMALL;
                end
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Sweep datapath and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tap_q       <= '0;
            settle_cnt  <= '0;
            word_cnt    <= '0;
            to_cnt      <= '0;
            pass_q      <= 1'b0;
            o_cal_busy  <= 1'b0;
            o_cal_done  <= 1'b0;
            o_cal_fail  <= 1'b0;
            o_err_code  <= 2'd0;
            o_dly_tap   <= TAP_W'(DEF_TAP);
            o_rd_req    <= 1'b0;
            o_win_start <= '0;
            o_win_len   <= '0;
`ifdef PSRAM_CAL_PASSMAP_EN
            o_pass_map  <= '0;
`endif
        end else begin
            o_rd_req   <= (state_d == ST_REQ);
            o_cal_done <= (state_d == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (i_cal_start) begin
                        tap_q      <= '0;
                        o_cal_busy <= 1'b1;
                        o_cal_fail <= 1'b0;
                        o_err_code <= 2'd0;
`ifdef PSRAM_CAL_PASSMAP_EN
                        o_pass_map <= '0;
`endif
                    end
                end
                ST_SET_TAP: begin
                    o_dly_tap  <= tap_q;
                    settle_cnt <= '0;
                end
                ST_SETTLE: settle_cnt <= settle_cnt + SCW'(1);
                ST_REQ: begin
                    if (i_rd_ack) begin
                        word_cnt <= '0;
                        to_cnt   <= '0;
                        pass_q   <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    to_cnt <= to_cnt + TCW'(1);
                    if (i_rd_vld) begin
                        word_cnt <= word_cnt + WCW'(1);
                        if (!word_ok) begin
                            pass_q <= 1'b0;
                        end
                    end
                end
                ST_EVAL: begin
`ifdef PSRAM_CAL_PASSMAP_EN
                    o_pass_map[tap_q] <= pass_q;
`endif
                    if (!last_tap) begin
                        tap_q <= tap_q + TAP_W'(1);
                    end
                end
                default: ;
            endcase
            if (state_d == ST_DONE) begin
                o_cal_busy  <= 1'b0;
                o_err_code  <= err_d;
                o_cal_fail  <= (err_d != CAL_OK);
                o_dly_tap   <= fin_tap;
                o_win_start <= best_start;
                o_win_len   <= best_len;
            end
        end
    end

endmodule

// File: tb/tb_psram_rd_dly_cal.sv
// Bench for psram_rd_dly_cal: a read responder passes or corrupts bursts per
// tap from a mask; results are checked against tables and a window model.
module tb_psram_rd_dly_cal;

    localparam int unsigned TIMEOUT = 1024;
    localparam int unsigned BURST   = 8;
    localparam logic [15:0] PAT     = 16'hA55A;
    localparam int          LIMIT   = 60000;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_cal_start = 1'b0;
    logic        o_cal_busy;
    logic        o_cal_done;
    logic        o_cal_fail;
    logic [1:0]  o_err_code;
    logic [4:0]  o_dly_tap;
    logic        o_rd_req;
    logic        i_rd_ack = 1'b0;
    logic        i_rd_vld = 1'b0;
    logic [15:0] i_rd_data = '0;
    logic [4:0]  o_win_start;
    logic [5:0]  o_win_len;
`ifdef PSRAM_CAL_PASSMAP_EN
    logic [31:0] o_pass_map;
`endif

    psram_rd_dly_cal dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_cal_start (i_cal_start),
        .o_cal_busy  (o_cal_busy),
        .o_cal_done  (o_cal_done),
        .o_cal_fail  (o_cal_fail),
        .o_err_code  (o_err_code),
        .o_dly_tap   (o_dly_tap),
        .o_rd_req    (o_rd_req),
        .i_rd_ack    (i_rd_ack),
        .i_rd_vld    (i_rd_vld),
        .i_rd_data   (i_rd_data),
        .o_win_start (o_win_start),
        .o_win_len   (o_win_len)
`ifdef PSRAM_CAL_PASSMAP_EN
        ,
        .o_pass_map  (o_pass_map)
`endif
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] pass_mask = '0;
    int          ack_dly = 0;
    int          withhold = -1;
    int          ack_cyc = 0;
    int          last_ack_tap = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] word_of(input int k);
        logic [31:0] dbl;
        dbl = {PAT, PAT} << k;
        return dbl[31:16];
    endfunction

    // Reference: longest run of set bits, lowest start on a tie, centred tap.
    function automatic void model(input logic [31:0] m, output logic [4:0] s,
                                  output logic [5:0] l, output logic [4:0] t,
                                  output logic [1:0] e);
        int bs, bl, i, j;
        bs = 0; bl = 0; i = 0;
        while (i < 32) begin
            if (m[i]) begin
                j = i;
                while (j < 32) begin
                    if (!m[j]) break;
                    j++;
                end
                if (j - i > bl) begin
                    bs = i;
                    bl = j - i;
                end
                i = j;
            end else begin
                i++;
            end
        end
        s = 5'(bs);
        l = 6'(bl);
        if (bl >= 4) begin
            t = 5'(bs + bl / 2);
            e = 2'd0;
        end else begin
            t = 5'd8;
            e = 2'd1;
        end
    endfunction

    // Controller/PHY responder: acks after ack_dly, then returns a burst.
    initial begin
        logic [4:0]  rtap;
        logic [15:0] d;
        int          bad_k, bad_b;
        forever begin
            @(posedge i_clk); #1;
            if (o_rd_req && !i_rst) begin
                rtap = o_dly_tap;
                for (int w = 0; w < ack_dly; w++) begin
                    chk("req_hold", 32'(o_rd_req), 32'd1);
                    @(posedge i_clk); #1;
                end
                i_rd_ack = 1'b1;
                @(posedge i_clk); #1;
                i_rd_ack = 1'b0;
                ack_cyc = cyc;
                last_ack_tap = int'(rtap);
                chk("req_drop", 32'(o_rd_req), 32'd0);
                if (int'(rtap) != withhold) begin
                    bad_k = int'($urandom_range(0, BURST - 1));
                    bad_b = int'($urandom_range(0, 15));
                    for (int k = 0; k < int'(BURST); k++) begin
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge i_clk); #1;
                        end
                        d = word_of(k);
                        if (!pass_mask[rtap] && k == bad_k) d = d ^ (16'd1 << bad_b);
                        i_rd_vld  = 1'b1;
                        i_rd_data = d;
                        @(posedge i_clk); #1;
                        i_rd_vld  = 1'b0;
                        i_rd_data = 16'h0000;
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge i_clk); #1;
        i_cal_start = 1'b1;
        @(posedge i_clk); #1;
        i_cal_start = 1'b0;
        chk("busy_rise", 32'(o_cal_busy), 32'd1);
    endtask

    task automatic wait_done(output bit got, output int dcyc);
        got = 1'b0;
        dcyc = 0;
        for (int n = 0; n < LIMIT; n++) begin
            @(negedge i_clk);
            if (o_cal_done) begin
                got = 1'b1;
                dcyc = cyc;
                break;
            end
        end
        if (!got) chk("done_wait", 32'd0, 32'd1);
    endtask

    task automatic run_cal(input logic [31:0] m, input int ad, input logic [4:0] es,
                           input logic [5:0] el, input logic [4:0] et, input logic [1:0] ee);
        bit got;
        int dc;
        pass_mask = m;
        ack_dly   = ad;
        withhold  = -1;
        pulse_start();
        wait_done(got, dc);
        if (got) begin
            chk("win_start", 32'(o_win_start), 32'(es));
            chk("win_len",   32'(o_win_len),   32'(el));
            chk("dly_tap",   32'(o_dly_tap),   32'(et));
            chk("err_code",  32'(o_err_code),  32'(ee));
            chk("cal_fail",  32'(o_cal_fail),  32'(ee != 2'd0));
            chk("busy_done", 32'(o_cal_busy),  32'd0);
`ifdef PSRAM_CAL_PASSMAP_EN
            chk("pass_map",  o_pass_map, m);
`endif
            @(negedge i_clk);
            chk("done_pulse", 32'(o_cal_done), 32'd0);
            chk("tap_hold",   32'(o_dly_tap),  32'(et));
        end
    endtask

    typedef struct {
        logic [31:0] mask;
        int          ad;
        logic [4:0]  st;
        logic [5:0]  len;
        logic [4:0]  tap;
        logic [1:0]  err;
    } vec_t;

    vec_t tbl[7];

    initial begin
        bit          got;
        int          dc;
        int          seen;
        logic [31:0] m;
        logic [4:0]  es, et;
        logic [5:0]  el;
        logic [1:0]  ee;

        tbl[0] = '{32'h000F_FC00, 5, 5'd10, 6'd10, 5'd15, 2'd0};
        tbl[1] = '{32'h00F0_0078, 0, 5'd3,  6'd4,  5'd5,  2'd0};
        tbl[2] = '{32'h07F0_0078, 1, 5'd20, 6'd7,  5'd23, 2'd0};
        tbl[3] = '{32'h0000_0007, 2, 5'd0,  6'd3,  5'd8,  2'd1};
        tbl[4] = '{32'hF000_0000, 0, 5'd28, 6'd4,  5'd30, 2'd0};
        tbl[5] = '{32'hFFFF_FFFF, 1, 5'd0,  6'd32, 5'd16, 2'd0};
        tbl[6] = '{32'h0000_0000, 0, 5'd0,  6'd0,  5'd8,  2'd1};

        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_tap",   32'(o_dly_tap),   32'd8);
        chk("rst_busy",  32'(o_cal_busy),  32'd0);
        chk("rst_done",  32'(o_cal_done),  32'd0);
        chk("rst_fail",  32'(o_cal_fail),  32'd0);
        chk("rst_err",   32'(o_err_code),  32'd0);
        chk("rst_req",   32'(o_rd_req),    32'd0);
        chk("rst_wst",   32'(o_win_start), 32'd0);
        chk("rst_wlen",  32'(o_win_len),   32'd0);

        for (int v = 0; v < 7; v++) begin
            run_cal(tbl[v].mask, tbl[v].ad, tbl[v].st, tbl[v].len, tbl[v].tap, tbl[v].err);
        end

        // Read timeout at tap 4 with a second start while busy.
        pass_mask = 32'hFFFF_FFFF;
        ack_dly = 1;
        withhold = 4;
        last_ack_tap = -1;
        pulse_start();
        got = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            @(negedge i_clk);
            if (last_ack_tap == 4) begin
                got = 1'b1;
                break;
            end
        end
        chk("to_reach_tap4", 32'(got), 32'd1);
        repeat (100) @(negedge i_clk);
        pulse_start();
        wait_done(got, dc);
        if (got) begin
            chk("to_latency", 32'(dc - ack_cyc), 32'(TIMEOUT));
            chk("to_err",     32'(o_err_code),  32'd2);
            chk("to_fail",    32'(o_cal_fail),  32'd1);
            chk("to_tap",     32'(o_dly_tap),   32'd8);
            seen = 0;
            repeat (40) begin
                @(negedge i_clk);
                if (o_cal_done) seen++;
            end
            chk("to_single_done", 32'(seen), 32'd0);
        end
        withhold = -1;

        // Reset in the middle of a capture burst.
        pass_mask = 32'hFFFF_FFFF;
        ack_dly = 0;
        last_ack_tap = -1;
        pulse_start();
        got = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            @(negedge i_clk);
            if (last_ack_tap == 6) begin
                got = 1'b1;
                break;
            end
        end
        chk("rst_reach_tap6", 32'(got), 32'd1);
        @(posedge i_clk); #1 i_rst = 1'b1;
        @(posedge i_clk); #1 i_rst = 1'b0;
        chk("mid_rst_tap",  32'(o_dly_tap),  32'd8);
        chk("mid_rst_busy", 32'(o_cal_busy), 32'd0);
        chk("mid_rst_done", 32'(o_cal_done), 32'd0);
        chk("mid_rst_req",  32'(o_rd_req),   32'd0);
`ifdef PSRAM_CAL_PASSMAP_EN
        chk("mid_rst_map",  o_pass_map,      32'd0);
`endif
        seen = 0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_cal_done || o_cal_busy) seen++;
        end
        chk("mid_rst_quiet", 32'(seen), 32'd0);
        run_cal(tbl[0].mask, tbl[0].ad, tbl[0].st, tbl[0].len, tbl[0].tap, tbl[0].err);

        // Randomized masks against the window model.
        for (int r = 0; r < 6; r++) begin
            if (r % 2 == 1) begin
                m = $urandom();
            end else begin
                m = '0;
                repeat ($urandom_range(0, 3)) begin
                    int st, ln;
                    st = int'($urandom_range(0, 31));
                    ln = int'($urandom_range(1, 10));
                    for (int k = 0; k < ln; k++) if (st + k < 32) m[st + k] = 1'b1;
                end
            end
            model(m, es, el, et, ee);
            run_cal(m, int'($urandom_range(0, 3)), es, el, et, ee);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
